// File: rtl/lagd_flip_decider.sv
// Flip decider feeding the flip manager's energy-history FIFO: fills a WINDOW of
// energies, then compares each new sample against the oldest one to decide a flip.
module lagd_flip_decider #(
   parameter int DATA_WIDTH = 32,
   parameter int WINDOW     = 8,
   parameter int CNT_W      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  stop_i,
   input  logic [DATA_WIDTH-1:0] energy_i,
   input  logic                  energy_skip_i,
   input  logic                  energy_valid_i,
   output logic                  energy_ready_o,
   input  logic                  fifo_full_i,
   input  logic                  fifo_empty_i,
   input  logic [DATA_WIDTH-1:0] fifo_head_i,
   output logic                  fifo_flush_o,
   output logic                  fifo_push_o,
   output logic                  fifo_push_none_o,
   output logic                  fifo_pop_o,
   output logic [DATA_WIDTH-1:0] fifo_data_o,
   output logic                  flip_valid_o,
   output logic                  flip_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [DATA_WIDTH-1:0] best_energy_o,
   output logic                  busy_o
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FLUSH = 3'd1;
   localparam logic [2:0] FILL  = 3'd2;
   localparam logic [2:0] RUN   = 3'd3;
   localparam logic [2:0] PUSH  = 3'd4;

   localparam int FILL_W = $clog2(WINDOW + 1);
   localparam logic [DATA_WIDTH-1:0] E_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [CNT_W-1:0]      CNT_MAX = '1;

   logic [2:0]            state_reg, state_next;
   logic [DATA_WIDTH-1:0] hold_energy_reg;
   logic                  hold_skip_reg;
   logic                  flip_valid_reg, flip_reg, busy_reg;
   logic [CNT_W-1:0]      stall_reg;
   logic [DATA_WIDTH-1:0] best_reg;
   logic [FILL_W-1:0]     fill_cnt_reg;
   logic                  accept, fill_push, run_accept, no_improve, sanity_err;

   assign energy_ready_o = (state_reg == FILL) ? ~fifo_full_i : (state_reg == RUN);
   assign accept         = energy_valid_i & energy_ready_o;
   assign fill_push      = (state_reg == FILL) & accept;
   assign run_accept     = (state_reg == RUN) & accept;
   assign no_improve     = $signed(energy_i) >= $signed(fifo_head_i);

   assign fifo_flush_o     = (state_reg == FLUSH);
   assign fifo_pop_o       = run_accept;
   assign fifo_push_o      = fill_push | (state_reg == PUSH);
   assign fifo_push_none_o = (state_reg == PUSH) ? hold_skip_reg : (fill_push & energy_skip_i);
   assign fifo_data_o      = (state_reg == PUSH) ? hold_energy_reg :
                             (fill_push ? energy_i : '0);

   assign flip_valid_o  = flip_valid_reg;
   assign flip_o        = flip_reg;
   assign stall_cnt_o   = stall_reg;
   assign best_energy_o = best_reg;
   assign busy_o        = busy_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start_i) state_next = FLUSH;
         FLUSH:   state_next = FILL;
         FILL: begin
            if (stop_i)           state_next = IDLE;
            else if (fifo_full_i) state_next = RUN;
         end
         RUN: begin
            if (accept)      state_next = PUSH;
            else if (stop_i) state_next = IDLE;
         end
         PUSH:    state_next = stop_i ? IDLE : RUN;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg       <= IDLE;
         busy_reg        <= 1'b0;
         hold_energy_reg <= '0;
         hold_skip_reg   <= 1'b0;
         flip_valid_reg  <= 1'b0;
         flip_reg        <= 1'b0;
         stall_reg       <= '0;
         best_reg        <= E_MAX;
         fill_cnt_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         busy_reg       <= (state_next != IDLE);
         flip_valid_reg <= 1'b0;

         if (state_reg == FLUSH) begin
            best_reg     <= E_MAX;
            stall_reg    <= '0;
            fill_cnt_reg <= '0;
         end else if (accept && !energy_skip_i &&
                      ($signed(energy_i) < $signed(best_reg))) begin
            best_reg <= energy_i;
         end

         if (fill_push && fill_cnt_reg != FILL_W'(WINDOW))
            fill_cnt_reg <= fill_cnt_reg + FILL_W'(1);

         if (run_accept) begin
            hold_energy_reg <= energy_i;
            hold_skip_reg   <= energy_skip_i;
            // Skipped samples still cycle the window but never count as a decision.
            if (!energy_skip_i) begin
               flip_valid_reg <= 1'b1;
               flip_reg       <= no_improve;
               if (!no_improve)           stall_reg <= '0;
               else if (stall_reg != CNT_MAX) stall_reg <= stall_reg + CNT_W'(1);
            end
         end
      end
   end

   // Popping an empty FIFO, or the FIFO reporting full at the wrong fill level,
   // means the decider and FIFO disagree about WINDOW.
   assign sanity_err = (fifo_pop_o & fifo_empty_i) |
                       ((state_reg == FILL) & fifo_full_i & (fill_cnt_reg != FILL_W'(WINDOW)));

   assert property (@(posedge clk_i) disable iff (!rst_ni) !sanity_err);

endmodule

// File: tb/tb_lagd_flip_decider.sv
// Directed bench for lagd_flip_decider with a behavioural history FIFO and a
// decision scoreboard checked whenever flip_valid pulses.
module tb_lagd_flip_decider;

   localparam int DW = 16;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0;
   logic [DW-1:0] energy = '0;
   logic          skip = 1'b0, valid = 1'b0;
   logic          ready, f_full, f_empty, f_flush, f_push, f_push_none, f_pop;
   logic [DW-1:0] f_head, f_data, best;
   logic          flip_valid, flip, busy;
   logic [CW-1:0] stall;

   always #5 clk = ~clk;

   lagd_flip_decider #(.DATA_WIDTH(DW), .WINDOW(4), .CNT_W(CW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
      .energy_i(energy), .energy_skip_i(skip), .energy_valid_i(valid),
      .energy_ready_o(ready), .fifo_full_i(f_full), .fifo_empty_i(f_empty),
      .fifo_head_i(f_head), .fifo_flush_o(f_flush), .fifo_push_o(f_push),
      .fifo_push_none_o(f_push_none), .fifo_pop_o(f_pop), .fifo_data_o(f_data),
      .flip_valid_o(flip_valid), .flip_o(flip), .stall_cnt_o(stall),
      .best_energy_o(best), .busy_o(busy)
   );

   // History FIFO: depth 4, registered head, reset slots = max positive,
   // push_none advances the write pointer but keeps the slot contents.
   logic [DW-1:0] fmem [4];
   logic [1:0]    wr_ptr, rd_ptr;
   logic [2:0]    fcnt;
   assign f_full  = (fcnt == 3'd4);
   assign f_empty = (fcnt == 3'd0);
   assign f_head  = fmem[rd_ptr];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0; rd_ptr <= '0; fcnt <= '0;
         for (int i = 0; i < 4; i++) fmem[i] <= 16'h7FFF;
      end else if (f_flush) begin
         wr_ptr <= '0; rd_ptr <= '0; fcnt <= '0;
      end else begin
         if (f_push) begin
            if (!f_push_none) fmem[wr_ptr] <= f_data;
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (f_pop) rd_ptr <= rd_ptr + 2'd1;
         fcnt <= fcnt + 3'(f_push) - 3'(f_pop);
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct packed { logic flip; logic [CW-1:0] stall; } exp_t;
   exp_t exp_q[$];

   logic signed [DW-1:0] ref_hist[$];
   logic signed [DW-1:0] ref_best;
   logic [CW-1:0]        ref_stall;

   always @(negedge clk) begin
      if (rst_n && flip_valid) begin
         chk("sb_pending", DW'(exp_q.size() != 0), 16'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_flip", DW'(flip), DW'(e.flip));
            chk("sb_stall", DW'(stall), DW'(e.stall));
         end
      end
   end

   task automatic do_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      #1;
      chk("flush_strobe", DW'(f_flush), 16'd1);
      chk("flush_ready", DW'(ready), 16'd0);
      chk("flush_busy", DW'(busy), 16'd1);
      ref_hist.delete();
      ref_best  = 16'sh7FFF;
      ref_stall = '0;
   endtask

   task automatic fill_sample(input logic signed [DW-1:0] e);
      @(negedge clk);
      valid = 1'b1; energy = e; skip = 1'b0;
      #1;
      chk("fill_ready", DW'(ready), 16'd1);
      chk("fill_push", DW'(f_push), 16'd1);
      chk("fill_data", f_data, e);
      chk("fill_pop", DW'(f_pop), 16'd0);
      ref_hist.push_back(e);
      if (e < ref_best) ref_best = e;
   endtask

   task automatic finish_fill();
      @(negedge clk) valid = 1'b0;
      #1;
      chk("full_ready", DW'(ready), 16'd0);
      chk("fill_no_flip", DW'(flip_valid), 16'd0);
      chk("fill_best", best, ref_best);
      @(negedge clk);
      #1;
      chk("run_ready", DW'(ready), 16'd1);
   endtask

   task automatic run_sample(input logic signed [DW-1:0] e, input logic s);
      logic signed [DW-1:0] head;
      logic                 f;
      @(negedge clk);
      valid = 1'b1; energy = e; skip = s;
      #1;
      chk("run_ready", DW'(ready), 16'd1);
      chk("run_pop", DW'(f_pop), 16'd1);
      chk("run_no_push", DW'(f_push), 16'd0);
      head = ref_hist.pop_front();
      ref_hist.push_back(s ? head : e);
      if (!s) begin
         f = (e >= head);
         if (!f)                  ref_stall = '0;
         else if (ref_stall != '1) ref_stall = ref_stall + 1'b1;
         if (e < ref_best) ref_best = e;
         exp_q.push_back('{flip: f, stall: ref_stall});
      end
      @(negedge clk);
      valid = 1'b0; skip = 1'b0;
      #1;
      chk("push_ready", DW'(ready), 16'd0);
      chk("push_strobe", DW'(f_push), 16'd1);
      chk("push_data", f_data, e);
      chk("push_none", DW'(f_push_none), DW'(s));
      chk("push_no_pop", DW'(f_pop), 16'd0);
      chk("flip_valid", DW'(flip_valid), DW'(!s));
      chk("run_best", best, ref_best);
      chk("run_stall", DW'(stall), DW'(ref_stall));
      $display("sample e=%0d skip=%0b flip_valid=%0b flip=%0b stall=%0d best=%0d",
               e, s, flip_valid, flip, stall, $signed(best));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, DW'(busy), 16'd0);
      chk({tag, "_ready"}, DW'(ready), 16'd0);
      chk({tag, "_best"}, best, 16'h7FFF);
      chk({tag, "_stall"}, DW'(stall), 16'd0);
      chk({tag, "_flip_valid"}, DW'(flip_valid), 16'd0);
      chk({tag, "_push"}, DW'(f_push), 16'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_state("in_reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk_reset_state("idle");

      do_start();
      fill_sample(16'sd100); fill_sample(16'sd90);
      fill_sample(16'sd80);  fill_sample(16'sd70);
      finish_fill();

      run_sample(16'sd60, 1'b0);
      run_sample(16'sd95, 1'b0);
      run_sample(16'sd85, 1'b0);
      run_sample(16'sd50, 1'b0);
      run_sample(16'sd5, 1'b1);
      for (int i = 0; i < 17; i++) run_sample(16'sd1000, 1'b0);
      chk("stall_saturated", DW'(stall), 16'd15);
      run_sample(-16'sd200, 1'b0);

      @(negedge clk) stop = 1'b1;
      @(negedge clk) stop = 1'b0;
      #1;
      chk("stop_busy", DW'(busy), 16'd0);
      chk("stop_ready", DW'(ready), 16'd0);

      do_start();
      fill_sample(16'sd10); fill_sample(16'sd20);
      fill_sample(16'sd30); fill_sample(16'sd40);
      finish_fill();
      run_sample(16'sd50, 1'b0);
      // Now in PUSH with a decision showing; reset must clear it immediately.
      #2 rst_n = 1'b0;
      #1 chk_reset_state("async_reset");
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);

      do_start();
      fill_sample(16'sd300); fill_sample(16'sd200); fill_sample(16'sd100);
      @(negedge clk) valid = 1'b0;
      #1;
      chk("refill_not_full", DW'(ready), 16'd1);
      chk("refill_no_flip", DW'(flip_valid), 16'd0);
      fill_sample(16'sd0);
      finish_fill();
      run_sample(16'sd250, 1'b0);

      repeat (2) @(negedge clk);
      chk("sb_drained", DW'(exp_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
